// File: rtl/uart_baud.sv
// rtl/uart_baud.sv - programmable baud tick generator with divisor-change detection
module uart_baud #(
    parameter int UBRR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [UBRR_W-1:0] UBRR,
    output logic              ubrr_changed,
    output logic              baud
);

    logic [UBRR_W-1:0] ubrr_q, ubrr_d;
    logic [UBRR_W-1:0] cnt_q, cnt_d;
    logic              baud_q, baud_d;
    logic              chg_q, chg_d;

    // A divisor change wins over the tick so the old period is abandoned outright.
    always_comb begin
        ubrr_d = ubrr_q;
        cnt_d  = cnt_q;
        baud_d = 1'b0;
        chg_d  = 1'b0;
        if (UBRR != ubrr_q) begin
            ubrr_d = UBRR;
            cnt_d  = '0;
            chg_d  = 1'b1;
        end else if (cnt_q == ubrr_q) begin
            cnt_d  = '0;
            baud_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ubrr_q <= '0;
            cnt_q  <= '0;
            baud_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            ubrr_q <= ubrr_d;
            cnt_q  <= cnt_d;
            baud_q <= baud_d;
            chg_q  <= chg_d;
        end
    end

    assign baud         = baud_q;
    assign ubrr_changed = chg_q;

endmodule

// File: tb/tb_uart_baud.sv
// tb/tb_uart_baud.sv - scoreboard bench for uart_baud tick timing and divisor adoption
module tb_uart_baud;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] UBRR;
    logic        ubrr_changed;
    logic        baud;

    typedef struct {
        int e;
        bit chg;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;
    int  edge_n = 0;
    bit  en = 1'b0;
    int  base;

    uart_baud #(.UBRR_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .UBRR         (UBRR),
        .ubrr_changed (ubrr_changed),
        .baud         (baud)
    );

    always #5 clk = ~clk;

    // Events carry the edge number after which the output must be high; everything else must be low.
    always @(posedge clk) begin
        logic exp_b, exp_c;
        edge_n++;
        #1;
        if (en) begin
            exp_b = 1'b0;
            exp_c = 1'b0;
            if (q.size() > 0 && q[0].e == edge_n) begin
                if (q[0].chg) exp_c = 1'b1;
                else          exp_b = 1'b1;
                void'(q.pop_front());
            end
            total++;
            assert (baud === exp_b) else begin
                bad++;
                $error("FAIL baud edge=%0d observed=%b expected=%b", edge_n, baud, exp_b);
            end
            total++;
            assert (ubrr_changed === exp_c) else begin
                bad++;
                $error("FAIL ubrr_changed edge=%0d observed=%b expected=%b", edge_n, ubrr_changed, exp_c);
            end
        end
    end

    task automatic sched(input int b, input bit chg, input int m, input int len);
        ev_t ev;
        if (chg) begin
            ev.e = b; ev.chg = 1'b1;
            q.push_back(ev);
        end
        for (int t = b + m + 1; t <= b + len; t += m + 1) begin
            ev.e = t; ev.chg = 1'b0;
            q.push_back(ev);
        end
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic adopt(input int m, input int len);
        UBRR = 12'(m);
        q.delete();
        base = edge_n + 1;
        sched(base, 1'b1, m, len);
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        assert (baud === 1'b0) else begin
            bad++;
            $error("FAIL %s_baud observed=%b expected=0", tag, baud);
        end
        total++;
        assert (ubrr_changed === 1'b0) else begin
            bad++;
            $error("FAIL %s_changed observed=%b expected=0", tag, ubrr_changed);
        end
    endtask

    initial begin
        rst  = 1'b1;
        UBRR = 12'd1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        en = 1'b1;

        // Release with UBRR=1: pulse on first edge, then alternate
        rst = 1'b0;
        base = edge_n + 1;
        sched(base, 1'b1, 1, 20);
        run_to(base + 20);

        // 9600 baud at 100 MHz, left mid-period
        adopt(2224, 2225 * 2 + 1000);
        run_to(base + 2225 * 2 + 1000);

        // 115200 baud mid-period switch, same-value rewrite in the middle
        adopt(868, 869 * 5);
        run_to(base + 869 * 3 + 10);
        UBRR = 12'd868;
        run_to(base + 869 * 5);

        // Divisor 0: tick every cycle
        adopt(0, 50);
        run_to(base + 50);

        // Full-scale divisor: period 4096
        adopt(4095, 4096 * 2 + 5);
        run_to(base + 4096 * 2 + 5);

        // Reset mid-period with non-zero divisor: re-adopted after release
        adopt(868, 400);
        run_to(base + 400);
        q.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        base = edge_n + 1;
        sched(base, 1'b1, 868, 869 * 2);
        run_to(base + 869 * 2);

        // Reset with divisor 0: no adoption pulse, counting starts immediately
        q.delete();
        rst  = 1'b1;
        UBRR = 12'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("zeroreset");
        rst = 1'b0;
        base = edge_n;
        sched(base, 1'b0, 0, 20);
        run_to(base + 20);

        total++;
        assert (q.size() === 0) else begin
            bad++;
            $error("FAIL pending_events observed=%0d expected=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_baud.md
UART_BAUD -- requirements
Module: uart_baud

Interface
REQ-001 Parameter UBRR_W, default 12: width of the divisor input and internal counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 UBRR  input  UBRR_W  baud divisor; tick period = UBRR+1 clocks; may change at any time.
REQ-005 ubrr_changed  output  1  registered one-cycle pulse indicating a new UBRR value was adopted.
REQ-006 baud  output  1  registered one-cycle baud tick.

Function
REQ-007 Block SHALL hold internal registers ubrr_q (UBRR_W bits, last adopted divisor) and cnt (UBRR_W bits, tick counter); outputs SHALL be registered, no combinational input-to-output path.
REQ-008 Each non-reset edge where UBRR != ubrr_q: ubrr_q <= UBRR, cnt <= 0, baud <= 0, ubrr_changed <= 1.
REQ-009 Each non-reset edge where UBRR == ubrr_q: ubrr_changed <= 0; if cnt == ubrr_q then cnt <= 0 and baud <= 1, else cnt <= cnt+1 and baud <= 0.
REQ-010 Steady state: baud SHALL be high for exactly one clock every ubrr_q+1 clocks.
REQ-011 Latency: after the edge adopting value M (ubrr_changed high), first baud high SHALL follow the edge M+1 clocks later; subsequent ticks every M+1 clocks.
REQ-012 ubrr_changed and baud SHALL never be high in the same cycle.
REQ-013 UBRR = 0: baud SHALL be high on every cycle after the cycle following adoption (period 1).
REQ-014 UBRR = all-ones (4095 at default width): period 4096 clocks; cnt SHALL never exceed ubrr_q, so no counter wrap-around occurs.
REQ-015 Divisor values wider than UBRR_W are truncated modulo 2^UBRR_W by the driver; block SHALL use the truncated value as-is.
REQ-016 Rewriting the same UBRR value SHALL NOT pulse ubrr_changed nor disturb counter phase.
REQ-017 UBRR change mid-period SHALL abandon the current period immediately (no tick for the old period) and restart from cnt = 0.
REQ-018 A change on consecutive cycles SHALL produce ubrr_changed on each of those cycles, counter held at 0.

Reset
REQ-019 With rst high at a rising edge: ubrr_q <= 0, cnt <= 0, baud <= 0, ubrr_changed <= 0; rst overrides all other conditions.
REQ-020 Reset mid-period SHALL discard counter phase; after release, if UBRR != 0 the first active edge adopts it per REQ-008 (ubrr_changed pulse), else counting starts from 0 with divisor 0.
REQ-021 Outputs SHALL be 0 during reset.

Verification
REQ-022 rst pulse, UBRR=1 held -> ubrr_changed one-cycle pulse on first edge after reset; then baud high 1 of every 2 clocks, alternating.
REQ-023 UBRR 1 -> 2224 (100000000/9600 truncated to 12 bits) -> one ubrr_changed pulse; baud ticks spaced exactly 2225 clocks, first tick 2225 clocks after adoption edge.
REQ-024 UBRR 2224 -> 868 (100000000/115200) mid-period -> ubrr_changed pulse, no residual tick from old period, ticks every 869 clocks.
REQ-025 UBRR=0 -> baud continuously high from second cycle after adoption; UBRR=4095 -> period 4096.
REQ-026 Rewrite same UBRR value and assert rst mid-period -> no ubrr_changed on rewrite; on reset both outputs 0, counting restarts per REQ-020.
